// File: rtl/fighter_motion.sv
// Per-player motion and pose controller for the DiveKick playfield.
// Updates position, vertical speed and pose once per synchronised frame tick.
module fighter_motion #(
    parameter logic [9:0] START_X  = 10'd100,
    parameter logic       MIRROR   = 1'b0,
    parameter logic [9:0] GROUND_Y = 10'd324,
    parameter logic [5:0] JUMP_V   = 6'd12,
    parameter logic [5:0] HOP_V    = 6'd8,
    parameter logic [5:0] HOP_VX   = 6'd3,
    parameter logic [5:0] KICK_V   = 6'd6
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       Freeze,
    input  logic       dive_key,
    input  logic       kick_key,
    input  logic [9:0] opp_X_Pos,
    output logic [9:0] X_Pos,
    output logic [9:0] Y_Pos,
    output logic [2:0] state
);

    typedef enum logic [1:0] {GROUND, JUMP, HOP, KICK} fsm_e;

    localparam logic signed [10:0] X_MAX = 11'sd568;
    localparam logic signed [10:0] KV    = {5'd0, KICK_V};
    localparam logic signed [10:0] HV    = {5'd0, HOP_VX};
    localparam logic signed [10:0] GY    = {1'b0, GROUND_Y};
    localparam logic signed [6:0]  JV    = {1'b0, JUMP_V};
    localparam logic signed [6:0]  HPV   = {1'b0, HOP_V};

    logic [2:0]        fsync_q;
    logic              tick;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic signed [6:0] vy_q, vy_d;
    fsm_e              fsm_q, fsm_d;
    logic              face_q, face_d;
    logic              dkey_q, dkey_d, kkey_q, kkey_d;
    logic [2:0]        pose_q;
    logic              dive_press, kick_press;

    logic signed [10:0] dx, dy, nx, ny;
    logic [9:0]         mx, my;
    logic signed [6:0]  mvy;
    fsm_e               mfsm;

    function automatic logic [2:0] pose_of(input fsm_e f, input logic fc);
        logic [2:0] b;
        case (f)
            GROUND:  b = 3'd0;
            KICK:    b = 3'd2;
            default: b = 3'd1;
        endcase
        // Same pose set, mirrored: add 3 when not facing the "native" way.
        if (!(fc ^ MIRROR))
            b = b + 3'd3;
        return b;
    endfunction

    assign tick = fsync_q[1] & ~fsync_q[2];

    // Candidate airborne update, used when no transition fires.
    always_comb begin
        case (fsm_q)
            KICK: begin
                dx = face_q ? KV : -KV;
                dy = KV;
            end
            HOP: begin
                dx = face_q ? -HV : HV;
                dy = {{4{vy_q[6]}}, vy_q};
            end
            default: begin
                dx = 11'sd0;
                dy = {{4{vy_q[6]}}, vy_q};
            end
        endcase
        nx   = $signed({1'b0, x_q}) + dx;
        ny   = $signed({1'b0, y_q}) + dy;
        mvy  = (fsm_q == KICK) ? 7'sd0 : vy_q + 7'sd1;
        mfsm = fsm_q;
        if (nx < 11'sd0)
            mx = 10'd0;
        else if (nx > X_MAX)
            mx = X_MAX[9:0];
        else
            mx = nx[9:0];
        if (ny < 11'sd0) begin
            my  = 10'd0;
            mvy = 7'sd0;
        end else if (ny >= GY) begin
            my   = GROUND_Y;
            mvy  = 7'sd0;
            mfsm = GROUND;
        end else begin
            my = ny[9:0];
        end
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        vy_d   = vy_q;
        fsm_d  = fsm_q;
        face_d = face_q;
        dkey_d = dkey_q;
        kkey_d = kkey_q;
        dive_press = dive_key & ~dkey_q;
        kick_press = kick_key & ~kkey_q;
        if (tick) begin
            // Key history advances even when frozen.
            dkey_d = dive_key;
            kkey_d = kick_key;
            if (!Freeze) begin
                unique case (fsm_q)
                    GROUND: begin
                        face_d = (x_q < opp_X_Pos);
                        if (dive_press) begin
                            fsm_d = JUMP;
                            vy_d  = -JV;
                        end else if (kick_press) begin
                            fsm_d = HOP;
                            vy_d  = -HPV;
                        end
                    end
                    JUMP, HOP: begin
                        if (kick_press) begin
                            fsm_d = KICK;
                            vy_d  = 7'sd0;
                        end else begin
                            x_d   = mx;
                            y_d   = my;
                            vy_d  = mvy;
                            fsm_d = mfsm;
                        end
                    end
                    KICK: begin
                        x_d   = mx;
                        y_d   = my;
                        vy_d  = mvy;
                        fsm_d = mfsm;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            fsync_q <= 3'b000;
            x_q     <= START_X;
            y_q     <= GROUND_Y;
            vy_q    <= 7'sd0;
            fsm_q   <= GROUND;
            face_q  <= (START_X < opp_X_Pos);
            dkey_q  <= 1'b0;
            kkey_q  <= 1'b0;
            pose_q  <= pose_of(GROUND, START_X < opp_X_Pos);
        end else begin
            fsync_q <= {fsync_q[1:0], frame_clk};
            x_q     <= x_d;
            y_q     <= y_d;
            vy_q    <= vy_d;
            fsm_q   <= fsm_d;
            face_q  <= face_d;
            dkey_q  <= dkey_d;
            kkey_q  <= kkey_d;
            pose_q  <= pose_of(fsm_d, face_d);
        end
    end

    assign X_Pos = x_q;
    assign Y_Pos = y_q;
    assign state = pose_q;

endmodule

// File: tb/tb_fighter_motion.sv
// Bench for fighter_motion: four instances with different placement/mirror
// parameters driven by shared keys and checked against an integer model.
module tb_fighter_motion;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       Freeze = 1'b0;
    logic       dive_key = 1'b0;
    logic       kick_key = 1'b0;
    logic [9:0] opp [4];
    logic [9:0] xo [4];
    logic [9:0] yo [4];
    logic [2:0] so [4];

    int vecs = 0;
    int errs = 0;

    localparam int SX  [4] = '{100, 1, 566, 300};
    localparam bit MIR [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam int GY = 324;
    localparam int S_GND = 0, S_JMP = 1, S_HOP = 2, S_KCK = 3;

    int mx [4];
    int my [4];
    int mvy [4];
    int mst [4];
    bit mface [4];
    bit mdp, mkp;

    always #5 Clk = ~Clk;

    fighter_motion #(.START_X(10'd100), .MIRROR(1'b0)) u0 (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .Freeze(Freeze),
        .dive_key(dive_key), .kick_key(kick_key), .opp_X_Pos(opp[0]),
        .X_Pos(xo[0]), .Y_Pos(yo[0]), .state(so[0]));
    fighter_motion #(.START_X(10'd1), .MIRROR(1'b0)) u1 (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .Freeze(Freeze),
        .dive_key(dive_key), .kick_key(kick_key), .opp_X_Pos(opp[1]),
        .X_Pos(xo[1]), .Y_Pos(yo[1]), .state(so[1]));
    fighter_motion #(.START_X(10'd566), .MIRROR(1'b0)) u2 (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .Freeze(Freeze),
        .dive_key(dive_key), .kick_key(kick_key), .opp_X_Pos(opp[2]),
        .X_Pos(xo[2]), .Y_Pos(yo[2]), .state(so[2]));
    fighter_motion #(.START_X(10'd300), .MIRROR(1'b1)) u3 (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .Freeze(Freeze),
        .dive_key(dive_key), .kick_key(kick_key), .opp_X_Pos(opp[3]),
        .X_Pos(xo[3]), .Y_Pos(yo[3]), .state(so[3]));

    function automatic int pose(input int i);
        int b;
        b = (mst[i] == S_GND) ? 0 : (mst[i] == S_KCK) ? 2 : 1;
        return b + ((mface[i] ^ MIR[i]) ? 0 : 3);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mx[i] = SX[i];
            my[i] = GY;
            mvy[i] = 0;
            mst[i] = S_GND;
            mface[i] = (SX[i] < int'(opp[i]));
        end
        mdp = 1'b0;
        mkp = 1'b0;
    endtask

    task automatic model_tick(input bit dk, input bit kk, input bit fz);
        bit dp, kp;
        int nx, ny, nvy;
        dp = dk && !mdp;
        kp = kk && !mkp;
        mdp = dk;
        mkp = kk;
        if (fz) return;
        for (int i = 0; i < 4; i++) begin
            if (mst[i] == S_GND) begin
                mface[i] = (mx[i] < int'(opp[i]));
                if (dp) begin
                    mst[i] = S_JMP;
                    mvy[i] = -12;
                end else if (kp) begin
                    mst[i] = S_HOP;
                    mvy[i] = -8;
                end
            end else if (mst[i] != S_KCK && kp) begin
                mst[i] = S_KCK;
                mvy[i] = 0;
            end else begin
                if (mst[i] == S_KCK) begin
                    nx = mx[i] + (mface[i] ? 6 : -6);
                    ny = my[i] + 6;
                    nvy = 0;
                end else begin
                    nx = mx[i];
                    if (mst[i] == S_HOP) nx = nx + (mface[i] ? -3 : 3);
                    ny = my[i] + mvy[i];
                    nvy = mvy[i] + 1;
                end
                if (nx < 0) nx = 0;
                if (nx > 568) nx = 568;
                if (ny < 0) begin
                    ny = 0;
                    nvy = 0;
                end
                if (ny >= GY) begin
                    ny = GY;
                    nvy = 0;
                    mst[i] = S_GND;
                end
                mx[i] = nx;
                my[i] = ny;
                mvy[i] = nvy;
            end
        end
    endtask

    // One video frame; compares every instance before, right after and
    // well after the tick so both latency and stability are covered.
    task automatic frame(input bit dk, input bit kk, input bit fz);
        @(negedge Clk);
        dive_key = dk;
        kick_key = kk;
        Freeze = fz;
        frame_clk = 1'b1;
        for (int ph = 0; ph < 3; ph++) begin
            if (ph == 0) begin
                repeat (2) @(negedge Clk);
            end else if (ph == 1) begin
                model_tick(dk, kk, fz);
                @(negedge Clk);
            end else begin
                repeat (3) @(negedge Clk);
                frame_clk = 1'b0;
                repeat (4) @(negedge Clk);
            end
            for (int i = 0; i < 4; i++) begin
                vecs++;
                if (xo[i] !== 10'(mx[i])) begin
                    errs++;
                    $display("FAIL frame_x u%0d ph%0d got %0d want %0d", i, ph, xo[i], mx[i]);
                end
                vecs++;
                if (yo[i] !== 10'(my[i])) begin
                    errs++;
                    $display("FAIL frame_y u%0d ph%0d got %0d want %0d", i, ph, yo[i], my[i]);
                end
                vecs++;
                if (so[i] !== 3'(pose(i))) begin
                    errs++;
                    $display("FAIL frame_state u%0d ph%0d got %0d want %0d", i, ph, so[i], pose(i));
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        dive_key = 1'b0;
        kick_key = 1'b0;
        Freeze = 1'b0;
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        model_reset();
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (xo[i] !== 10'(mx[i]) || yo[i] !== 10'(my[i]) || so[i] !== 3'(pose(i))) begin
                errs++;
                $display("FAIL reset u%0d got %0d/%0d/%0d want %0d/%0d/%0d", i, xo[i], yo[i], so[i], mx[i], my[i], pose(i));
            end
        end
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        opp[0] = 10'd500;
        opp[1] = 10'd600;
        opp[2] = 10'd600;
        opp[3] = 10'd50;
        do_reset();
        vecs++;
        if (xo[0] !== 10'd100 || yo[0] !== 10'd324 || so[0] !== 3'd0) begin
            errs++;
            $display("FAIL reset_const got %0d/%0d/%0d want 100/324/0", xo[0], yo[0], so[0]);
        end
        vecs++;
        if (so[3] !== 3'd0) begin
            errs++;
            $display("FAIL mirror_left got %0d want 0", so[3]);
        end
    endtask

    task automatic test_mirror();
        opp[3] = 10'd600;
        frame(0, 0, 0);
        vecs++;
        if (so[3] !== 3'd3) begin
            errs++;
            $display("FAIL mirror_right got %0d want 3", so[3]);
        end
    endtask

    task automatic test_backhop();
        frame(0, 1, 0);
        frame(0, 0, 0);
        vecs++;
        if (xo[1] !== 10'd0 || yo[1] !== 10'd316 || so[1] !== 3'd1) begin
            errs++;
            $display("FAIL backhop_wall got %0d/%0d/%0d want 0/316/1", xo[1], yo[1], so[1]);
        end
        repeat (19) frame(0, 0, 0);
        vecs++;
        if (xo[1] !== 10'd0 || yo[1] !== 10'd324 || so[1] !== 3'd0) begin
            errs++;
            $display("FAIL backhop_land got %0d/%0d/%0d want 0/324/0", xo[1], yo[1], so[1]);
        end
    endtask

    task automatic test_dive_jump();
        int ey [5] = '{312, 301, 291, 282, 274};
        frame(1, 0, 0);
        for (int k = 1; k <= 25; k++) begin
            if (k == 2) opp[3] = 10'd50;
            frame(0, 0, 0);
            if (k <= 5) begin
                vecs++;
                if (yo[0] !== 10'(ey[k-1]) || so[0] !== 3'd1) begin
                    errs++;
                    $display("FAIL jump_y t%0d got %0d/%0d want %0d/1", k, yo[0], so[0], ey[k-1]);
                end
            end
            if (k == 4) begin
                vecs++;
                if (so[3] !== 3'd4) begin
                    errs++;
                    $display("FAIL face_frozen got %0d want 4", so[3]);
                end
            end
        end
        vecs++;
        if (yo[0] !== 10'd324 || so[0] !== 3'd0) begin
            errs++;
            $display("FAIL jump_land got %0d/%0d want 324/0", yo[0], so[0]);
        end
    endtask

    task automatic test_kick();
        int ey [6] = '{297, 303, 309, 315, 321, 324};
        do_reset();
        frame(1, 0, 0);
        repeat (3) frame(0, 0, 0);
        frame(0, 1, 0);
        vecs++;
        if (xo[0] !== 10'd100 || yo[0] !== 10'd291 || so[0] !== 3'd2) begin
            errs++;
            $display("FAIL kick_enter got %0d/%0d/%0d want 100/291/2", xo[0], yo[0], so[0]);
        end
        for (int k = 0; k < 6; k++) begin
            frame(0, (k == 1), 0);
            vecs++;
            if (yo[0] !== 10'(ey[k]) || xo[0] !== 10'(106 + 6 * k) ||
                so[0] !== ((k < 5) ? 3'd2 : 3'd0)) begin
                errs++;
                $display("FAIL kick_step k%0d got %0d/%0d/%0d want %0d/%0d", k, xo[0], yo[0], so[0], 106 + 6 * k, ey[k]);
            end
        end
        vecs++;
        if (xo[2] !== 10'd568) begin
            errs++;
            $display("FAIL kick_wall got %0d want 568", xo[2]);
        end
    endtask

    task automatic test_freeze();
        logic [9:0] sx, sy;
        logic [2:0] ss;
        frame(1, 0, 0);
        repeat (4) frame(0, 0, 0);
        sx = xo[0];
        sy = yo[0];
        ss = so[0];
        for (int k = 0; k < 10; k++) begin
            frame(1, 1, 1);
            vecs++;
            if (xo[0] !== sx || yo[0] !== sy || so[0] !== ss) begin
                errs++;
                $display("FAIL freeze_hold k%0d got %0d/%0d/%0d want %0d/%0d/%0d", k, xo[0], yo[0], so[0], sx, sy, ss);
            end
        end
        frame(1, 1, 0);
        vecs++;
        if (yo[0] !== 10'd274 || so[0] !== 3'd1) begin
            errs++;
            $display("FAIL freeze_resume got %0d/%0d want 274/1", yo[0], so[0]);
        end
        repeat (22) frame(0, 0, 0);
    endtask

    task automatic test_reset_midair();
        frame(1, 0, 0);
        repeat (3) frame(0, 0, 0);
        do_reset();
        vecs++;
        if (yo[0] !== 10'd324 || so[0] !== 3'd0) begin
            errs++;
            $display("FAIL reset_midair got %0d/%0d want 324/0", yo[0], so[0]);
        end
    endtask

    task automatic test_random();
        bit dk, kk, fz;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0)
                opp[$urandom_range(0, 3)] = 10'($urandom_range(0, 700));
            dk = ($urandom_range(0, 3) == 0);
            kk = ($urandom_range(0, 3) == 0);
            fz = ($urandom_range(0, 9) == 0);
            frame(dk, kk, fz);
        end
    endtask

    initial begin
        opp[0] = 10'd500;
        opp[1] = 10'd600;
        opp[2] = 10'd600;
        opp[3] = 10'd50;
        test_reset();
        test_mirror();
        test_backhop();
        test_dive_jump();
        test_kick();
        test_freeze();
        test_reset_midair();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
